// File: rtl/nn_layer_core.sv
// Fully-connected layer engine: streams activation/weight chunks from block RAM,
// accumulates one signed dot product per neuron and writes it to the output RAM.
`timescale 1ns/1ps
module nn_layer_core #(
  parameter int LANES = 128,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic        nnclk,
  input  logic        nnreset,
  input  logic        nnstart,
  input  logic [9:0]  num_of_input,
  input  logic [4:0]  num_of_output,
  output logic [31:0] data_addr,
  output logic [31:0] data_din,
  input  logic [31:0] data_dout,
  output logic        data_en,
  output logic [3:0]  data_we,
  output logic [31:0] weight_addr,
  output logic [31:0] weight_din,
  input  logic [31:0] weight_dout,
  output logic        weight_en,
  output logic [3:0]  weight_we,
  output logic [31:0] output_addr,
  output logic [31:0] output_din,
  input  logic [31:0] output_dout,
  output logic        output_en,
  output logic [3:0]  output_we,
  output logic [31:0] inst_addr,
  output logic [15:0] inst_din,
  input  logic [15:0] inst_dout,
  output logic        inst_en,
  output logic [3:0]  inst_we,
  output logic        nnend
);
  localparam int WORDS = LANES / 4;
  localparam int KW    = $clog2(WORDS);

  typedef enum logic [2:0] {IDLE, LOAD, CAPTURE, MAC, WRITE, DONE} state_t;

  state_t                  state;
  logic                    start_q;
  logic [9:0]              ni;
  logic [4:0]              no;
  logic [9:0]              nc;
  logic [9:0]              c;
  logic [4:0]              j;
  logic [KW-1:0]           k;
  logic [KW-1:0]           cap_k;
  logic                    cap_valid;
  logic                    nn128write;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [DW-1:0]           data   [0:LANES-1];
  logic signed [DW-1:0]    weight [0:LANES-1];
  logic                    unused_ok;

  assign data_din   = '0;
  assign weight_din = '0;
  assign data_we    = '0;
  assign weight_we  = '0;
  assign inst_addr  = '0;
  assign inst_din   = '0;
  assign inst_en    = 1'b0;
  assign inst_we    = '0;
  assign unused_ok  = ^{output_dout, inst_dout};

  assign nc = 10'((32'(ni) + LANES - 1) / LANES);

  function automatic logic [31:0] d_addr(input logic [9:0] cc, input logic [KW-1:0] kk);
    return 32'(cc) * 32'(LANES) + 32'(kk) * 32'd4;
  endfunction

  // Weight rows are padded to a whole number of chunks, so row j starts at j*nc*LANES.
  function automatic logic [31:0] w_addr(input logic [4:0] jj, input logic [9:0] cc,
                                         input logic [KW-1:0] kk);
    return 32'(jj) * 32'(nc) * 32'(LANES) + d_addr(cc, kk);
  endfunction

  // NOTE: lane_sum is assigned before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++)
      lane_sum = lane_sum + ACC_W'($signed({1'b0, data[l]}) * weight[l]);
  end

  assign acc_next = acc + lane_sum;

  // NOTE: every register here uses <=, so capture, MAC and the FSM all see pre-edge values.
  always_ff @(posedge nnclk) begin
    if (nnreset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      ni          <= '0;
      no          <= '0;
      c           <= '0;
      j           <= '0;
      k           <= '0;
      cap_k       <= '0;
      cap_valid   <= 1'b0;
      nn128write  <= 1'b0;
      acc         <= '0;
      data_addr   <= '0;
      weight_addr <= '0;
      data_en     <= 1'b0;
      weight_en   <= 1'b0;
      output_addr <= '0;
      output_din  <= '0;
      output_en   <= 1'b0;
      output_we   <= '0;
      nnend       <= 1'b0;
      // NOTE: the lane arrays are flops with a defined reset value, not a RAM, so they are cleared here.
      for (int l = 0; l < LANES; l++) begin
        data[l]   <= '0;
        weight[l] <= '0;
      end
    end else begin
      start_q    <= nnstart;
      nn128write <= 1'b0;
      output_en  <= 1'b0;
      output_we  <= '0;
      cap_valid  <= data_en;
      cap_k      <= k;

      // Read data arrives one cycle after issue; lanes past the last input are zeroed.
      if (cap_valid) begin
        for (int b = 0; b < 4; b++) begin
          if (int'(c) * LANES + int'(cap_k) * 4 + b >= int'(ni))
            data[int'(cap_k) * 4 + b] <= '0;
          else
            data[int'(cap_k) * 4 + b] <= data_dout[8*b +: 8];
          weight[int'(cap_k) * 4 + b] <= weight_dout[8*b +: 8];
        end
      end

      unique case (state)
        IDLE, DONE: begin
          if (nnstart && !start_q) begin
            ni    <= num_of_input;
            no    <= num_of_output;
            c     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            nnend <= 1'b0;
            if (num_of_input == '0 || num_of_output == '0) begin
              state <= DONE;
              nnend <= 1'b1;
            end else begin
              state       <= LOAD;
              data_en     <= 1'b1;
              weight_en   <= 1'b1;
              data_addr   <= '0;
              weight_addr <= '0;
            end
          end
        end
        LOAD: begin
          if (k == KW'(WORDS - 1)) begin
            state     <= CAPTURE;
            data_en   <= 1'b0;
            weight_en <= 1'b0;
          end else begin
            k           <= k + 1'b1;
            data_addr   <= d_addr(c, KW'(k + 1'b1));
            weight_addr <= w_addr(j, c, KW'(k + 1'b1));
          end
        end
        CAPTURE: begin
          state      <= MAC;
          nn128write <= 1'b1;
        end
        MAC: begin
          if ({1'b0, c} == {1'b0, nc} - 11'd1) begin
            state       <= WRITE;
            output_en   <= 1'b1;
            output_we   <= 4'hF;
            output_addr <= 32'(j) * 32'd4;
            output_din  <= 32'(acc_next);
            acc         <= '0;
          end else begin
            if (nn128write) acc <= acc_next;
            state       <= LOAD;
            c           <= c + 1'b1;
            k           <= '0;
            data_en     <= 1'b1;
            weight_en   <= 1'b1;
            data_addr   <= d_addr(c + 1'b1, '0);
            weight_addr <= w_addr(j, c + 1'b1, '0);
          end
        end
        WRITE: begin
          if (j == no - 1'b1) begin
            state <= DONE;
            nnend <= 1'b1;
          end else begin
            state       <= LOAD;
            j           <= j + 1'b1;
            c           <= '0;
            k           <= '0;
            data_en     <= 1'b1;
            weight_en   <= 1'b1;
            data_addr   <= '0;
            weight_addr <= w_addr(j + 1'b1, '0, '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_layer_core.sv
// Scoreboard bench for nn_layer_core: RAM models, a software dot-product model and
// an access/write monitor that pops expected transactions as the DUT presents them.
`timescale 1ns/1ps
module tb_nn_layer_core;
  logic        nnclk = 1'b0;
  logic        nnreset, nnstart;
  logic [9:0]  num_of_input;
  logic [4:0]  num_of_output;
  logic [31:0] data_addr, data_din, data_dout, weight_addr, weight_din, weight_dout;
  logic [31:0] output_addr, output_din, output_dout, inst_addr;
  logic        data_en, weight_en, output_en, inst_en, nnend;
  logic [3:0]  data_we, weight_we, output_we, inst_we;
  logic [15:0] inst_din, inst_dout;

  logic [31:0] data_mem   [0:1023];
  logic [31:0] weight_mem [0:8191];
  logic [63:0] rd_q[$];
  logic [63:0] wr_q[$];
  int checks = 0, errors = 0, mac_cnt = 0;

  nn_layer_core dut (
    .nnclk(nnclk), .nnreset(nnreset), .nnstart(nnstart),
    .num_of_input(num_of_input), .num_of_output(num_of_output),
    .data_addr(data_addr), .data_din(data_din), .data_dout(data_dout),
    .data_en(data_en), .data_we(data_we),
    .weight_addr(weight_addr), .weight_din(weight_din), .weight_dout(weight_dout),
    .weight_en(weight_en), .weight_we(weight_we),
    .output_addr(output_addr), .output_din(output_din), .output_dout(output_dout),
    .output_en(output_en), .output_we(output_we),
    .inst_addr(inst_addr), .inst_din(inst_din), .inst_dout(inst_dout),
    .inst_en(inst_en), .inst_we(inst_we), .nnend(nnend)
  );

  always #5 nnclk = ~nnclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous RAMs with one cycle read latency.
  always @(posedge nnclk) begin
    if (data_en)   data_dout   <= data_mem[data_addr[11:2]];
    if (weight_en) weight_dout <= weight_mem[weight_addr[14:2]];
  end

  // Monitor: every RAM read and every output write must match the next queued expectation.
  always @(negedge nnclk) begin
    logic [63:0] exp;
    if (!nnreset) begin
      if (data_en || weight_en) begin
        exp = (rd_q.size() != 0) ? rd_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check("ram_read_addr", {data_addr, weight_addr}, exp);
        check("ram_en_pair", 64'(weight_en), 64'(data_en));
      end
      if (output_en) begin
        exp = (wr_q.size() != 0) ? wr_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
        check("output_write", {output_addr, output_din}, exp);
        check("output_we", 64'(output_we), 64'hF);
      end
      if (dut.nn128write) mac_cnt++;
    end
  end

  function automatic int dbyte(input int i);
    return int'((data_mem[i / 4] >> (8 * (i % 4))) & 32'hFF);
  endfunction

  function automatic int wbyte(input int a);
    int w;
    w = int'((weight_mem[a / 4] >> (8 * (a % 4))) & 32'hFF);
    return (w > 127) ? w - 256 : w;
  endfunction

  // Reference model: queue the read sequence and the dot products a run must produce.
  task automatic expect_run(input int ni, input int no, output int exp_cyc, output int exp_mac);
    int nc, rs;
    longint acc;
    nc = (ni + 127) / 128;
    rs = nc * 128;
    if (ni == 0 || no == 0) begin
      exp_cyc = 0;
      exp_mac = 0;
      return;
    end
    for (int j = 0; j < no; j++)
      for (int c = 0; c < nc; c++)
        for (int k = 0; k < 32; k++)
          rd_q.push_back({32'(4 * (32 * c + k)), 32'(j * rs + 128 * c + 4 * k)});
    for (int j = 0; j < no; j++) begin
      acc = 0;
      for (int i = 0; i < ni; i++) acc += longint'(dbyte(i)) * longint'(wbyte(j * rs + i));
      wr_q.push_back({32'(4 * j), 32'(acc)});
    end
    exp_cyc = no * (nc * 34 + 1);
    exp_mac = no * nc;
  endtask

  task automatic run(input int ni, input int no, input bit hold);
    int exp_cyc, exp_mac, cyc, mac0;
    expect_run(ni, no, exp_cyc, exp_mac);
    mac0 = mac_cnt;
    @(negedge nnclk);
    nnstart       = 1'b0;
    num_of_input  = 10'(ni);
    num_of_output = 5'(no);
    @(negedge nnclk);
    nnstart = 1'b1;
    @(posedge nnclk);
    #1;
    if (exp_cyc != 0) check("nnend_cleared", 64'(nnend), 64'd0);
    cyc = 0;
    while (!nnend && cyc < 20000) begin
      @(posedge nnclk);
      cyc++;
      #1;
    end
    check("run_cycles", 64'(cyc), 64'(exp_cyc));
    if (!hold) begin
      @(negedge nnclk);
      nnstart = 1'b0;
    end
    repeat (3) @(negedge nnclk);
    check("mac_pulses", 64'(mac_cnt - mac0), 64'(exp_mac));
    check("writes_drained", 64'(wr_q.size()), 64'd0);
    check("reads_drained", 64'(rd_q.size()), 64'd0);
    check("nnend_level", 64'(nnend), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_addr"}, {data_addr, weight_addr}, 64'd0);
    check({tag, "_out"}, {output_addr, output_din}, 64'd0);
    check({tag, "_din"}, {data_din, weight_din}, 64'd0);
    check({tag, "_inst"}, 64'({inst_addr, inst_din}), 64'd0);
    check({tag, "_ctrl"}, 64'({data_en, weight_en, output_en, nnend, data_we, weight_we,
                               output_we, inst_we, inst_en}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cyc, exp_mac, nz, t;
    nnreset = 1'b1;
    nnstart = 1'b0;
    num_of_input  = '0;
    num_of_output = '0;
    output_dout = '0;
    inst_dout   = '0;
    data_dout   = '0;
    weight_dout = '0;
    for (int i = 0; i < 1024; i++) data_mem[i] = $urandom;
    for (int i = 0; i < 8192; i++) weight_mem[i] = $urandom;

    // Reset for two cycles, then idle with nnstart low.
    repeat (2) @(posedge nnclk);
    @(negedge nnclk);
    nnreset = 1'b0;
    repeat (5) @(negedge nnclk);
    check_idle_outputs("reset");

    // Single neuron, four inputs; the rest of the chunk must be zero-padded.
    data_mem[0]   = 32'h0403_0201;
    weight_mem[0] = 32'hFF02_0101;
    fork
      run(4, 1, 1'b0);
      begin
        for (t = 0; t < 200 && !dut.nn128write; t++) @(negedge nnclk);
        check("mac_seen", 64'(dut.nn128write), 64'd1);
        nz = 0;
        for (int l = 4; l < 128; l++) if (dut.data[l] != 0) nz++;
        check("pad_lanes_zero", 64'(nz), 64'd0);
        check("lanes_0_3", 64'({dut.data[3], dut.data[2], dut.data[1], dut.data[0]}),
              64'h0403_0201);
      end
    join

    // Two chunks per neuron, saturated data and most-negative weights.
    for (int i = 0; i < 1024; i++) data_mem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 8192; i++) weight_mem[i] = 32'h8080_8080;
    run(129, 2, 1'b0);

    // Full-size layer with random memories.
    for (int i = 0; i < 1024; i++) data_mem[i] = $urandom;
    for (int i = 0; i < 8192; i++) weight_mem[i] = $urandom;
    run(785, 30, 1'b0);

    // Zero inputs: straight to DONE without touching memory.
    run(0, 5, 1'b0);

    // Reset in the middle of LOAD, then restart.
    expect_run(200, 2, exp_cyc, exp_mac);
    @(negedge nnclk);
    num_of_input  = 10'd200;
    num_of_output = 5'd2;
    nnstart       = 1'b1;
    @(negedge nnclk);
    nnstart = 1'b0;
    repeat (10) @(negedge nnclk);
    nnreset = 1'b1;
    @(posedge nnclk);
    #1;
    rd_q.delete();
    wr_q.delete();
    check_idle_outputs("abort");
    check("abort_lane_data", 64'({dut.data[0], dut.data[4], dut.data[8]}), 64'd0);
    check("abort_lane_weight", 64'({dut.weight[0], dut.weight[4], dut.weight[8]}), 64'd0);
    @(negedge nnclk);
    nnreset = 1'b0;
    repeat (5) @(negedge nnclk);
    run(200, 2, 1'b0);

    // nnstart held high after completion must not relaunch; a fresh edge must.
    run(20, 1, 1'b1);
    repeat (40) @(negedge nnclk);
    check("held_start_no_rerun", 64'(nnend), 64'd1);
    data_mem[0] = $urandom;
    run(20, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
